// File: rtl/uart_irq_pkg.sv
// Shared types and sizing helpers for the UART interrupt controller.
package uart_irq_pkg;

  localparam int NUM_SRC_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } irq_state_e;

  // Id width, kept at least one bit so a single-source build still has a port.
  function automatic int irq_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_gateway.sv
// One interrupt source: synchroniser, delay flop, edge/level select and pending flop.
module irq_gateway #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic irq_i,
  input  logic edge_i,
  input  logic inhibit_i,
  input  logic clear_i,
  output logic pending_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic                   pending_q, pending_d;
  logic                   s;
  logic                   set;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = irq_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    dly_d = s;
    // Level sources are held off while their own claim is outstanding.
    set = edge_i ? (s & ~dly_q) : (s & ~inhibit_i);
    if (set) begin
      pending_d = 1'b1;
    end else if (clear_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      sync_q    <= '0;
      dly_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      dly_q     <= dly_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/uart_irq_ctrl.sv
// Fixed-priority interrupt controller with a claim/complete handshake to the core.
module uart_irq_ctrl
  import uart_irq_pkg::*;
#(
  parameter int NUM_SRC     = NUM_SRC_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk_i,
  input  logic                            arst_ni,
  input  logic [NUM_SRC-1:0]              irq_i,
  input  logic [NUM_SRC-1:0]              cfg_edge_i,
  input  logic [NUM_SRC-1:0]              cfg_mask_i,
  output logic [NUM_SRC-1:0]              pending_o,
  output logic                            claim_valid_o,
  output logic [irq_id_w(NUM_SRC)-1:0]    claim_id_o,
  input  logic                            claim_ready_i,
  input  logic                            complete_i,
  input  logic [irq_id_w(NUM_SRC)-1:0]    complete_id_i,
  output logic                            complete_err_o,
  output logic                            irq_o
);

  localparam int ID_W = irq_id_w(NUM_SRC);

  irq_state_e         state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               err_q, err_d;
  logic [NUM_SRC-1:0] pending, eligible, clear, inhibit;
  logic [ID_W-1:0]    win_id;
  logic               accept;

  assign accept = (state_q == OFFER) && claim_ready_i;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign clear[gi]   = accept && (id_q == ID_W'(gi));
    assign inhibit[gi] = (state_q != IDLE) && (id_q == ID_W'(gi));

    irq_gateway #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_gw (
      .clk_i    (clk_i),
      .arst_ni  (arst_ni),
      .irq_i    (irq_i[gi]),
      .edge_i   (cfg_edge_i[gi]),
      .inhibit_i(inhibit[gi]),
      .clear_i  (clear[gi]),
      .pending_o(pending[gi])
    );
  end

  assign eligible = pending & cfg_mask_i;

  // Ascending scan so the highest eligible index overwrites lower ones.
  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i]) begin
        win_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        err_d = complete_i;
        if (|eligible) begin
          id_d    = win_id;
          state_d = OFFER;
        end
      end
      OFFER: begin
        err_d = complete_i;
        if (claim_ready_i) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (complete_i) begin
          if (complete_id_i == id_q) begin
            state_d = IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign pending_o      = pending;
  assign claim_valid_o  = (state_q == OFFER);
  assign claim_id_o     = id_q;
  assign complete_err_o = err_q;
  assign irq_o          = claim_valid_o;

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Directed bench: cycle-by-cycle vector table plus hand-written corner sequences.
module tb_uart_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq;
  logic [7:0] cfg_edge;
  logic [7:0] cfg_mask;
  logic [7:0] pending;
  logic       claim_valid;
  logic [2:0] claim_id;
  logic       claim_ready;
  logic       complete;
  logic [2:0] complete_id;
  logic       complete_err;
  logic       irq_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] irq;
    logic       ready;
    logic       cmp;
    logic [2:0] cid;
    logic [7:0] exp_pend;
    logic       exp_valid;
    logic [2:0] exp_id;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  uart_irq_ctrl #(
    .NUM_SRC(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i         (clk),
    .arst_ni       (rst_n),
    .irq_i         (irq),
    .cfg_edge_i    (cfg_edge),
    .cfg_mask_i    (cfg_mask),
    .pending_o     (pending),
    .claim_valid_o (claim_valid),
    .claim_id_o    (claim_id),
    .claim_ready_i (claim_ready),
    .complete_i    (complete),
    .complete_id_i (complete_id),
    .complete_err_o(complete_err),
    .irq_o         (irq_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] p, input logic v,
                           input logic [2:0] id, input logic e);
    chk({tag, " pend"}, 32'(pending), 32'(p));
    chk({tag, " valid"}, 32'(claim_valid), 32'(v));
    chk({tag, " irq_o"}, 32'(irq_out), 32'(v));
    chk({tag, " err"}, 32'(complete_err), 32'(e));
    if (v) chk({tag, " id"}, 32'(claim_id), 32'(id));
    $display("%s: pend=%02h valid=%0b id=%0d err=%0b", tag, pending, claim_valid, claim_id,
             complete_err);
  endtask

  initial begin
    rst_n       = 1'b0;
    irq         = 8'h00;
    cfg_edge    = 8'hFF;
    cfg_mask    = 8'hFF;
    claim_ready = 1'b0;
    complete    = 1'b0;
    complete_id = 3'd0;
    step();
    chk("reset id", 32'(claim_id), 32'd0);
    chk_state("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    step();

    // Edge pulse on 5, priority 4 over 1, completion errors in IDLE and BUSY.
    vecs.push_back('{8'h20, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h20, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h20, 1'b1, 3'd5, 1'b0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h12, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h12, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h12, 1'b1, 3'd4, 1'b0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 3'd0, 8'h02, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b1, 3'd4, 8'h02, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h02, 1'b1, 3'd1, 1'b0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h10, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h10, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h10, 1'b1, 3'd4, 1'b0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 3'd0, 1'b1});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 3'd0, 1'b1});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0});

    foreach (vecs[i]) begin
      irq         = vecs[i].irq;
      claim_ready = vecs[i].ready;
      complete    = vecs[i].cmp;
      complete_id = vecs[i].cid;
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].exp_pend, vecs[i].exp_valid,
                vecs[i].exp_id, vecs[i].exp_err);
    end
    claim_ready = 1'b0;
    complete    = 1'b0;

    // Mask: level source 3 pends while masked, offered one edge after unmask.
    cfg_edge = 8'h00;
    cfg_mask = 8'hF7;
    irq      = 8'h08;
    for (int i = 0; i < 6; i++) step();
    chk_state("mask pend", 8'h08, 1'b0, 3'd0, 1'b0);
    cfg_mask = 8'hFF;
    step();
    chk_state("mask unmask", 8'h08, 1'b1, 3'd3, 1'b0);
    cfg_mask = 8'hF7;
    step();
    chk_state("mask hold", 8'h08, 1'b1, 3'd3, 1'b0);
    claim_ready = 1'b1;
    irq         = 8'h00;
    step();
    chk_state("mask accept", 8'h00, 1'b0, 3'd0, 1'b0);
    claim_ready = 1'b0;
    complete    = 1'b1;
    complete_id = 3'd3;
    step();
    complete = 1'b0;
    cfg_mask = 8'hFF;
    step();
    step();
    chk_state("mask done", 8'h00, 1'b0, 3'd0, 1'b0);

    // Level re-offer: source 2 held high across claim and complete.
    irq = 8'h04;
    step(); step(); step();
    chk_state("lvl pend", 8'h04, 1'b0, 3'd0, 1'b0);
    step();
    chk_state("lvl offer", 8'h04, 1'b1, 3'd2, 1'b0);
    claim_ready = 1'b1;
    step();
    chk_state("lvl accept", 8'h00, 1'b0, 3'd0, 1'b0);
    claim_ready = 1'b0;
    complete    = 1'b1;
    complete_id = 3'd2;
    step();
    chk_state("lvl c", 8'h00, 1'b0, 3'd0, 1'b0);
    complete = 1'b0;
    step();
    chk_state("lvl c+1", 8'h04, 1'b0, 3'd0, 1'b0);
    step();
    chk_state("lvl c+2", 8'h04, 1'b1, 3'd2, 1'b0);
    irq         = 8'h00;
    claim_ready = 1'b1;
    step();
    claim_ready = 1'b0;
    complete    = 1'b1;
    step();
    complete = 1'b0;
    step();
    step();
    chk_state("lvl done", 8'h00, 1'b0, 3'd0, 1'b0);

    // Reset while an offer is outstanding.
    cfg_edge = 8'hFF;
    irq      = 8'h40;
    step();
    irq = 8'h00;
    step(); step(); step();
    chk_state("rst offer", 8'h40, 1'b1, 3'd6, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst id", 32'(claim_id), 32'd0);
    chk_state("rst applied", 8'h00, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk_state("rst quiet", 8'h00, 1'b0, 3'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
